inverse_predictor: RTL and testbench

Inverse of the 5/3 lifting predict step, used on the synthesis (reconstruction) side of the DWT.
- Accepts a stream of (even sample, detail coefficient) pairs.
- Reconstructs each odd sample as x[2n+1] = d[n] + floor((x[2n] + x[2n+2]) / 2).
- Emits the interleaved sequence x[0], x[1], x[2], ... on a valid/ready stream to the next inverse stage or to the sample sink.

---
 rtl/dwt_pkg.sv | 27 ++
 rtl/inverse_predictor_if.sv | 28 ++
 rtl/inv_pred_alu.sv | 36 +++
 rtl/inverse_predictor.sv | 138 +++++++++++++
 tb/tb_inverse_predictor.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dwt_pkg.sv
// Shared types for the 5/3 inverse lifting stages: sample width, the
// (even, detail, last) pair carried into the inverse predictor, and its
// FSM state encoding.
package dwt_pkg;

    localparam int DATA_W = 16;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic signed [DATA_W:0]   wide_t;

    typedef struct packed {
        sample_t even;
        sample_t detail;
        logic    last;
    } pair_t;

    typedef enum logic [1:0] {
        EMPTY,
        HELD,
        OUT_EVEN,
        OUT_ODD
    } inv_pred_state_t;

    localparam sample_t SAMPLE_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam sample_t SAMPLE_MIN = {1'b1, {(DATA_W-1){1'b0}}};

endpackage

// File: rtl/inverse_predictor_if.sv
// Stream interface of the inverse predictor: a pair stream in and an
// interleaved sample stream out, both valid/ready.
interface inverse_predictor_if;
    import dwt_pkg::*;

    sample_t even_in;
    sample_t detail_in;
    logic    valid_in;
    logic    last_in;
    logic    in_ready;
    sample_t data_out;
    logic    valid_out;
    logic    last_out;
    logic    out_ready;

    // Block side.
    modport slave (
        input  even_in, detail_in, valid_in, last_in, out_ready,
        output in_ready, data_out, valid_out, last_out
    );

    // Source/sink side.
    modport master (
        output even_in, detail_in, valid_in, last_in, out_ready,
        input  in_ready, data_out, valid_out, last_out
    );

endinterface

// File: rtl/inv_pred_alu.sv
// Odd-sample reconstruction: odd = d + floor((e_a + e_b) / 2).
// Build option: INV_PRED_SAT_EN makes the final add saturate instead of wrap.
module inv_pred_alu
    import dwt_pkg::*;
(
    input  sample_t e_a,
    input  sample_t e_b,
    input  sample_t d,
    output sample_t odd
);

    wide_t sum;
    wide_t half;
`ifdef INV_PRED_SAT_EN
    wide_t total;
`endif

    // Widen by one bit so the even sum cannot overflow; >>> floors negatives.
    always_comb begin
        sum  = wide_t'(e_a) + wide_t'(e_b);
        half = sum >>> 1;
`ifdef INV_PRED_SAT_EN
        total = half + wide_t'(d);
        if (total > wide_t'(SAMPLE_MAX)) begin
            odd = SAMPLE_MAX;
        end else if (total < wide_t'(SAMPLE_MIN)) begin
            odd = SAMPLE_MIN;
        end else begin
            odd = sample_t'(total);
        end
`else
        odd = sample_t'(half + wide_t'(d));
`endif
    end

endmodule

// File: rtl/inverse_predictor.sv
// Inverse 5/3 predict step: turns (x[2n], d[n]) pairs back into the
// interleaved sample stream x[0], x[1], x[2], ...
// The last pair of a line uses symmetric extension (x[2n+2] := x[2n]).
// Build option: INV_PRED_SAT_EN (saturating odd-sample add, see inv_pred_alu).
module inverse_predictor
    import dwt_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    inverse_predictor_if.slave  bus
);

    inv_pred_state_t state_q, state_d;

    // held_q.last doubles as the flush flag: it is set exactly when the held
    // pair closes the line.
    pair_t   held_q;
    pair_t   next_q;
    pair_t   in_pair;
    sample_t odd_q;

    sample_t alu_ea, alu_eb, alu_d, alu_odd;
    logic    in_ready, valid_out;
    logic    in_xfer, out_xfer;

    assign in_pair  = '{even: bus.even_in, detail: bus.detail_in, last: bus.last_in};
    assign in_xfer  = bus.valid_in && in_ready;
    assign out_xfer = valid_out && bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.valid_out = valid_out;

    // State register.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:    if (in_xfer)  state_d = bus.last_in ? OUT_EVEN : HELD;
            HELD:     if (in_xfer)  state_d = OUT_EVEN;
            OUT_EVEN: if (out_xfer) state_d = OUT_ODD;
            OUT_ODD:  if (out_xfer) state_d = held_q.last ? EMPTY
                                            : (next_q.last ? OUT_EVEN : HELD);
            default:  state_d = EMPTY;
        endcase
    end

    // Output decode: only state and held registers, so data is stable under stall.
    always_comb begin
        in_ready     = 1'b0;
        valid_out    = 1'b0;
        bus.data_out = '0;
        bus.last_out = 1'b0;
        case (state_q)
            EMPTY, HELD: in_ready = 1'b1;
            OUT_EVEN: begin
                valid_out    = 1'b1;
                bus.data_out = held_q.even;
            end
            OUT_ODD: begin
                valid_out    = 1'b1;
                bus.data_out = odd_q;
                bus.last_out = held_q.last;
            end
            default: ;
        endcase
    end

    // ALU operand select: neighbour pair in HELD, self-extension otherwise.
    always_comb begin
        alu_ea = bus.even_in;
        alu_eb = bus.even_in;
        alu_d  = bus.detail_in;
        case (state_q)
            HELD: begin
                alu_ea = held_q.even;
                alu_d  = held_q.detail;
            end
            OUT_ODD: begin
                alu_ea = next_q.even;
                alu_eb = next_q.even;
                alu_d  = next_q.detail;
            end
            default: ;
        endcase
    end

    inv_pred_alu u_alu (
        .e_a (alu_ea),
        .e_b (alu_eb),
        .d   (alu_d),
        .odd (alu_odd)
    );

    // Held/next pair and odd-sample registers.
    // NOTE: these are reset too, so a line started after reset never sees a stale pair.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            held_q <= '0;
            next_q <= '0;
            odd_q  <= '0;
        end else begin
            case (state_q)
                EMPTY: if (in_xfer) begin
                    held_q <= in_pair;
                    if (bus.last_in) begin
                        odd_q <= alu_odd;
                    end
                end
                HELD: if (in_xfer) begin
                    next_q <= in_pair;
                    odd_q  <= alu_odd;
                end
                OUT_ODD: if (out_xfer) begin
                    if (held_q.last) begin
                        held_q.last <= 1'b0;
                    end else begin
                        held_q <= next_q;
                        if (next_q.last) begin
                            odd_q <= alu_odd;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inverse_predictor.sv
// Self-checking bench for inverse_predictor: directed lines plus random
// lines with random backpressure, against an arithmetic reference model.
module tb_inverse_predictor;
    import dwt_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inverse_predictor_if bus ();

    inverse_predictor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int ev[8];
    int dv[8];

    // Reference: d + floor((e0 + e1) / 2), wrapped or clamped to DATA_W bits.
    function automatic sample_t ref_odd(int e0, int e1, int d);
        int s, half, t;
        s    = e0 + e1;
        half = (s >= 0) ? s / 2 : (s - 1) / 2;
        t    = d + half;
`ifdef INV_PRED_SAT_EN
        if (t > (1 << (DATA_W-1)) - 1) t = (1 << (DATA_W-1)) - 1;
        if (t < -(1 << (DATA_W-1)))    t = -(1 << (DATA_W-1));
`endif
        return sample_t'(t);
    endfunction

    function automatic void set_pair(int i, logic [DATA_W-1:0] e, logic [DATA_W-1:0] d);
        ev[i] = int'($signed(e));
        dv[i] = int'($signed(d));
    endfunction

    // Drives n pairs from ev/dv and checks the 2n outputs; bp: 0 none, 1 random, 2 hold 3 cycles.
    task automatic run_line(input string name, input int n, input int bp);
        sample_t exp_d[16];
        bit      exp_l[16];
        for (int i = 0; i < n; i++) begin
            exp_d[2*i]   = sample_t'(ev[i]);
            exp_d[2*i+1] = ref_odd(ev[i], (i == n-1) ? ev[i] : ev[i+1], dv[i]);
            exp_l[2*i]   = 1'b0;
            exp_l[2*i+1] = (i == n-1);
        end
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    int cyc = 0;
                    if (bp == 1 && $urandom_range(0, 3) == 0) begin
                        bus.valid_in = 1'b0;
                        @(posedge clk); #1;
                    end
                    bus.valid_in  = 1'b1;
                    bus.even_in   = sample_t'(ev[i]);
                    bus.detail_in = sample_t'(dv[i]);
                    bus.last_in   = (i == n-1);
                    while (!bus.in_ready && cyc < 200) begin
                        @(posedge clk); #1;
                        cyc++;
                    end
                    if (cyc >= 200) begin
                        checks++; errors++;
                        $display("FAIL %s input_timeout: pair %0d never accepted", name, i);
                        break;
                    end
                    @(posedge clk); #1;
                end
                bus.valid_in = 1'b0;
                bus.last_in  = 1'b0;
            end
            begin
                int      idx = 0;
                int      cyc = 0;
                int      hold = 0;
                bit      stall = 1'b0;
                bit      r;
                sample_t pd;
                bit      pl;
                while (idx < 2*n && cyc < 400) begin
                    if (stall) begin
                        checks++;
                        if (bus.valid_out !== 1'b1 || bus.data_out !== pd || bus.last_out !== pl) begin
                            errors++;
                            $display("FAIL %s stall_stable: got v=%b d=%h l=%b, required v=1 d=%h l=%b",
                                     name, bus.valid_out, bus.data_out, bus.last_out, pd, pl);
                        end
                    end
                    case (bp)
                        0: r = 1'b1;
                        1: r = 1'($urandom_range(0, 1));
                        default: begin
                            if (bus.valid_out && hold < 3) begin
                                r = 1'b0;
                                hold++;
                            end else begin
                                r = 1'b1;
                            end
                        end
                    endcase
                    bus.out_ready = r;
                    if (bus.valid_out === 1'b1) begin
                        checks++;
                        if (bus.in_ready !== 1'b0) begin
                            errors++;
                            $display("FAIL %s in_ready_low: got %b, required 0", name, bus.in_ready);
                        end
                        if (r) begin
                            checks++;
                            if (bus.data_out !== exp_d[idx] || bus.last_out !== exp_l[idx]) begin
                                errors++;
                                $display("FAIL %s sample[%0d]: got %h last=%b, required %h last=%b",
                                         name, idx, bus.data_out, bus.last_out, exp_d[idx], exp_l[idx]);
                            end
                            idx++;
                            stall = 1'b0;
                            hold  = 0;
                        end else begin
                            stall = 1'b1;
                            pd    = bus.data_out;
                            pl    = bus.last_out;
                        end
                    end else begin
                        stall = 1'b0;
                    end
                    @(posedge clk); #1;
                    cyc++;
                end
                bus.out_ready = 1'b0;
                if (idx < 2*n) begin
                    checks++; errors++;
                    $display("FAIL %s output_timeout: got %0d samples, required %0d", name, idx, 2*n);
                end
                checks++;
                if (bus.in_ready !== 1'b1 || bus.valid_out !== 1'b0) begin
                    errors++;
                    $display("FAIL %s line_done: got in_ready=%b valid_out=%b, required 1/0",
                             name, bus.in_ready, bus.valid_out);
                end
            end
        join
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.valid_in = 1'b0; bus.last_in = 1'b0; bus.out_ready = 1'b0;
        bus.even_in = '0; bus.detail_in = '0;
        #1;
        checks++;
        if (bus.valid_out !== 1'b0 || bus.last_out !== 1'b0 || bus.data_out !== '0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got v=%b l=%b d=%h rdy=%b, required 0 0 0000 1",
                     bus.valid_out, bus.last_out, bus.data_out, bus.in_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_line();
        set_pair(0, 16'h1111, 16'h0000);
        set_pair(1, 16'h3333, 16'h0000);
        set_pair(2, 16'h5555, 16'h1111);
        run_line("basic", 3, 0);
    endtask

    task automatic test_backpressure();
        set_pair(0, 16'h1111, 16'h0000);
        set_pair(1, 16'h3333, 16'h0000);
        set_pair(2, 16'h5555, 16'h1111);
        run_line("backpressure", 3, 2);
    endtask

    task automatic test_single_pair();
        sample_t exp_odd;
        set_pair(0, 16'h0100, 16'h0005);
        exp_odd = ref_odd(ev[0], ev[0], dv[0]);
        bus.out_ready = 1'b0;
        bus.valid_in  = 1'b1;
        bus.even_in   = sample_t'(ev[0]);
        bus.detail_in = sample_t'(dv[0]);
        bus.last_in   = 1'b1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready: got %b, required 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        bus.last_in  = 1'b0;
        checks++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== sample_t'(ev[0]) || bus.last_out !== 1'b0) begin
            errors++;
            $display("FAIL single_even_latency: got v=%b d=%h l=%b, required 1 %h 0",
                     bus.valid_out, bus.data_out, bus.last_out, sample_t'(ev[0]));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== exp_odd || bus.last_out !== 1'b1) begin
            errors++;
            $display("FAIL single_odd: got v=%b d=%h l=%b, required 1 %h 1",
                     bus.valid_out, bus.data_out, bus.last_out, exp_odd);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL single_done: got rdy=%b v=%b, required 1 0", bus.in_ready, bus.valid_out);
        end
    endtask

    task automatic test_negative_floor();
        set_pair(0, 16'hFFFF, 16'h0000);
        set_pair(1, 16'h0000, 16'h0000);
        run_line("neg_floor", 2, 0);
    endtask

    task automatic test_overflow();
        set_pair(0, 16'h7FFF, 16'h0001);
        set_pair(1, 16'h7FFF, 16'h0000);
        run_line("overflow", 2, 1);
        set_pair(0, 16'h8000, 16'hFFFF);
        set_pair(1, 16'h8000, 16'h0000);
        run_line("underflow", 2, 0);
    endtask

    task automatic test_reset_mid_line();
        bus.valid_in  = 1'b1;
        bus.even_in   = 16'h7000;
        bus.detail_in = 16'h0123;
        bus.last_in   = 1'b0;
        @(posedge clk); #1;
        bus.even_in   = 16'h6000;
        bus.detail_in = 16'h0456;
        @(posedge clk); #1;
        bus.valid_in  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.valid_out !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre: got v=%b, required 1", bus.valid_out);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.valid_out !== 1'b0 || bus.last_out !== 1'b0 || bus.data_out !== '0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_async: got v=%b l=%b d=%h rdy=%b, required 0 0 0000 1",
                     bus.valid_out, bus.last_out, bus.data_out, bus.in_ready);
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        set_pair(0, 16'h0010, 16'h0002);
        set_pair(1, 16'hFFF0, 16'h0003);
        run_line("after_reset", 2, 0);
    endtask

    task automatic test_random();
        for (int l = 0; l < 25; l++) begin
            int n;
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                set_pair(i, 16'($urandom), 16'($urandom));
            end
            run_line("random", n, $urandom_range(0, 2));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_line();
        test_backpressure();
        test_single_pair();
        test_negative_floor();
        test_overflow();
        test_reset_mid_line();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
